// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/compare ops plus an iterative shift-add multiply.
// Define ALU_MC_DIV_EN to add iterative restoring DIVU/REMU (ops 12/13).
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic             imm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] ext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             true_flag,
  output logic [1:0]       dbg_state
);

  // Handshake: a request transfers on a rising edge with in_valid && in_ready;
  // a result transfers on a rising edge with out_valid && out_ready.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SHL1 = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SHR1 = OP_W'(3);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_EQ   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_LTU  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_NE   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_TRUE = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(11);
`ifdef ALU_MC_DIV_EN
  localparam logic [OP_W-1:0] OP_DIVU = OP_W'(12);
  localparam logic [OP_W-1:0] OP_REMU = OP_W'(13);
`endif

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;      // MUL: shifting multiplicand; DIV: quotient/dividend
  logic [WIDTH-1:0] b_q, b_d;      // MUL: shifting multiplier; DIV: divisor
  logic [WIDTH-1:0] acc_q, acc_d;  // MUL: partial product; DIV: partial remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q, flag_d;
`ifdef ALU_MC_DIV_EN
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             rem_ge;
`endif

  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sc_res;
  logic             sc_flag;
  logic             is_multi;
  logic [WIDTH-1:0] mul_acc_nx;

  assign op_b = imm ? ext : b;

  always_comb begin
    sc_res   = '0;
    sc_flag  = 1'b0;
    is_multi = 1'b0;
    case (op)
      OP_ADD:  sc_res = a + op_b;
      OP_SUB:  sc_res = a - op_b;
      OP_SHL1: sc_res = a << 1;
      OP_SHR1: sc_res = a >> 1;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_NOT:  sc_res = ~a;
      OP_EQ:   begin sc_flag = (a == b);    sc_res = WIDTH'(sc_flag); end
      OP_LTU:  begin sc_flag = (a < op_b);  sc_res = WIDTH'(sc_flag); end
      OP_NE:   begin sc_flag = (a != b);    sc_res = WIDTH'(sc_flag); end
      OP_TRUE: sc_flag = 1'b1;
      OP_MUL:  is_multi = 1'b1;
`ifdef ALU_MC_DIV_EN
      OP_DIVU, OP_REMU: is_multi = 1'b1;
`endif
      default: ;
    endcase
  end

  assign mul_acc_nx = acc_q + (b_q[0] ? a_q : '0);

`ifdef ALU_MC_DIV_EN
  // Remainder stays below the divisor, so the top bit of the difference is the borrow.
  assign rem_sh  = {acc_q, a_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign rem_ge  = ~rem_sub[WIDTH];
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_d   = flag_q;
`ifdef ALU_MC_DIV_EN
    op_d     = op_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = op_b;
          acc_d = '0;
          cnt_d = '0;
`ifdef ALU_MC_DIV_EN
          op_d  = op;
`endif
          if (is_multi) begin
            state_d = S_CALC;
          end else begin
            result_d = sc_res;
            flag_d   = sc_flag;
            state_d  = S_DONE;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
`ifdef ALU_MC_DIV_EN
        if (op_q == OP_MUL) begin
          acc_d = mul_acc_nx;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], rem_ge};
        end
`else
        acc_d = mul_acc_nx;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
`endif
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          flag_d  = 1'b0;
          state_d = S_DONE;
`ifdef ALU_MC_DIV_EN
          result_d = (op_q == OP_DIVU) ? a_d : acc_d;
`else
          result_d = acc_d;
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
`ifdef ALU_MC_DIV_EN
      op_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_q   <= flag_d;
`ifdef ALU_MC_DIV_EN
      op_q     <= op_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign true_flag = flag_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vector table, hand-written hold/reset sequences,
// and random operations checked against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic         imm;
  logic [W-1:0] a, b, ext;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         true_flag;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    string        name;
    logic [4:0]   op;
    logic         imm;
    logic [W-1:0] a, b, ext;
    logic [W-1:0] r;
    logic         f;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  alu_multicycle #(.WIDTH(W), .OP_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .imm(imm), .a(a), .b(b), .ext(ext),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .true_flag(true_flag), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model straight from the op table; latency in cycles after acceptance.
  task automatic ref_model(input logic [4:0] o, input logic im, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] e,
                           output logic [W-1:0] r, output logic f, output int lat);
    logic [W-1:0] bb;
    logic [63:0]  prod;
    bb   = im ? e : y;
    r    = '0;
    f    = 1'b0;
    lat  = 1;
    prod = {32'b0, x} * {32'b0, bb};
    case (o)
      5'd0:  r = x + bb;
      5'd1:  r = x - bb;
      5'd2:  r = x * 2;
      5'd3:  r = x / 2;
      5'd4:  r = x & y;
      5'd5:  r = x | y;
      5'd6:  r = ~x;
      5'd7:  begin f = (x == y); r = {31'b0, f}; end
      5'd8:  begin f = (x < bb); r = {31'b0, f}; end
      5'd9:  begin f = (x != y); r = {31'b0, f}; end
      5'd10: f = 1'b1;
      5'd11: begin r = prod[W-1:0]; lat = W + 1; end
`ifdef ALU_MC_DIV_EN
      5'd12: begin r = (bb == 0) ? {W{1'b1}} : x / bb; lat = W + 1; end
      5'd13: begin r = (bb == 0) ? x : x % bb; lat = W + 1; end
`endif
      default: ;
    endcase
  endtask

  // driver: issue one op, scramble inputs while busy, optionally stall in DONE, then release
  task automatic do_op(input logic [4:0] o, input logic im, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] e, input int hold,
                       output logic [W-1:0] r, output logic f, output int lat);
    logic busy_bad;
    logic hold_bad;
    busy_bad = 1'b0;
    hold_bad = 1'b0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    op = o; imm = im; a = x; b = y; ext = e; in_valid = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready !== 1'b0) busy_bad = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      op = 5'($urandom); imm = 1'($urandom); a = $urandom; b = $urandom; ext = $urandom;
      @(negedge clk);
      lat++;
    end
    chk("out_valid_timeout", (lat >= 200), 0);
    chk("busy_in_ready", busy_bad, 0);
    r = result;
    f = true_flag;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = $urandom;
      @(negedge clk);
      if (result !== r || true_flag !== f || out_valid !== 1'b1 || in_ready !== 1'b0)
        hold_bad = 1'b1;
    end
    if (hold > 0) chk("done_hold_stable", hold_bad, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("release_result_held", {true_flag, result}, {f, r});
  endtask

  task automatic add_vec(input string nm, input logic [4:0] o, input logic im,
                         input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] e,
                         input logic [W-1:0] r, input logic f, input int lat);
    vec_t v;
    v.name = nm; v.op = o; v.imm = im; v.a = x; v.b = y; v.ext = e;
    v.r = r; v.f = f; v.lat = lat;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] r, er;
    logic         f, ef;
    int           lat, elat;
    logic         seen_valid;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; imm = 1'b0; a = '0; b = '0; ext = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_true_flag", true_flag, 0);
    reset = 1'b0;

    add_vec("add_imm_wrap", 5'd0,  1, 32'd5, 32'd77, 32'hFFFF_FFFF, 32'd4, 0, 1);
    add_vec("sub_imm",      5'd1,  1, 32'd3, 32'd1, 32'd5, 32'hFFFF_FFFE, 0, 1);
    add_vec("shl1",         5'd2,  0, 32'h8000_0001, 32'd0, 32'd0, 32'h0000_0002, 0, 1);
    add_vec("shr1",         5'd3,  0, 32'h8000_0001, 32'd0, 32'd0, 32'h4000_0000, 0, 1);
    add_vec("and_ignores_imm", 5'd4, 1, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'h0000_F000, 0, 1);
    add_vec("or",           5'd5,  0, 32'h0000_F0F0, 32'h0000_0F0F, 32'd0, 32'h0000_FFFF, 0, 1);
    add_vec("not",          5'd6,  0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 1);
    add_vec("eq_true",      5'd7,  0, 32'd9, 32'd9, 32'd0, 32'd1, 1, 1);
    add_vec("ltu_true",     5'd8,  0, 32'd3, 32'd7, 32'd0, 32'd1, 1, 1);
    add_vec("ltu_false_imm",5'd8,  1, 32'd3, 32'd7, 32'd2, 32'd0, 0, 1);
    add_vec("ne_false",     5'd9,  0, 32'd9, 32'd9, 32'd0, 32'd0, 0, 1);
    add_vec("true_op",      5'd10, 0, 32'd1, 32'd2, 32'd3, 32'd0, 1, 1);
    add_vec("mul",          5'd11, 0, 32'h0001_0000, 32'h0003_0001, 32'd0, 32'h0001_0000, 0, 33);
    add_vec("mul_imm",      5'd11, 1, 32'd3, 32'd100, 32'd7, 32'd21, 0, 33);
    add_vec("undef_14",     5'd14, 0, 32'd5, 32'd6, 32'd7, 32'd0, 0, 1);
    add_vec("undef_31",     5'd31, 1, 32'd5, 32'd6, 32'd7, 32'd0, 0, 1);
`ifdef ALU_MC_DIV_EN
    add_vec("divu",         5'd12, 0, 32'd100, 32'd7, 32'd0, 32'd14, 0, 33);
    add_vec("remu",         5'd13, 0, 32'd100, 32'd7, 32'd0, 32'd2, 0, 33);
    add_vec("divu_by0",     5'd12, 0, 32'd100, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 33);
    add_vec("remu_by0",     5'd13, 0, 32'd100, 32'd0, 32'd0, 32'd100, 0, 33);
`else
    add_vec("divu_off",     5'd12, 0, 32'd100, 32'd7, 32'd0, 32'd0, 0, 1);
    add_vec("remu_off",     5'd13, 0, 32'd100, 32'd7, 32'd0, 32'd0, 0, 1);
    add_vec("divu_by0_off", 5'd12, 0, 32'd100, 32'd0, 32'd0, 32'd0, 0, 1);
`endif

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].imm, vecs[i].a, vecs[i].b, vecs[i].ext, 0, r, f, lat);
      chk({vecs[i].name, "_result"}, r, vecs[i].r);
      chk({vecs[i].name, "_flag"}, f, vecs[i].f);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].lat);
    end

    // stall 5 cycles in DONE with in_valid asserted
    do_op(5'd6, 0, 32'h0000_00FF, 32'd0, 32'd0, 5, r, f, lat);
    chk("hold_result", r, 32'hFFFF_FF00);

    // reset at cycle 10 of a MUL: discarded, no out_valid
    @(negedge clk);
    op = 5'd11; imm = 1'b0; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_mul_busy", in_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flag", true_flag, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    chk("midrst_no_out_valid", seen_valid, 0);

    // random ops against the model
    for (int n = 0; n < 60; n++) begin
      logic [4:0]   ro;
      logic         ri;
      logic [W-1:0] ra, rb, re;
      ro = 5'($urandom_range(0, 14));
      if (ro == 5'd14) ro = 5'($urandom_range(12, 31));
      ri = 1'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 4) == 0) rb = ra;
      re = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      ref_model(ro, ri, ra, rb, re, er, ef, elat);
      exp_q.push_back(er);
      do_op(ro, ri, ra, rb, re, $urandom_range(0, 2), r, f, lat);
      chk($sformatf("rand%0d_op%0d_result", n, ro), r, exp_q.pop_front());
      chk($sformatf("rand%0d_op%0d_flag", n, ro), f, ef);
      chk($sformatf("rand%0d_op%0d_latency", n, ro), lat, elat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
